// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port scoreboarded register file.
// The init-value helper works at the widest supported width; callers size-cast it down to XLEN.
package regfile_pkg;

  localparam int RF_MAX_XLEN = 64;

  typedef enum logic {RF_INIT, RF_RUN} rf_state_e;

  localparam logic [RF_MAX_XLEN-1:0] RF_X0 = '0;

  // Mode 1 gives the debug pattern reg[i] = i. Any other mode gives all zero.
  function automatic logic [RF_MAX_XLEN-1:0] rf_init_val(input int unsigned idx, input int mode);
    logic [RF_MAX_XLEN-1:0] val;
    val = RF_X0;
    if (mode == 1) val = RF_MAX_XLEN'(idx);
    return val;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Holds one pending bit per register for each in-flight load. It also gives the busy flag for each read port.
// A load issue takes priority over a load return on the same register in the same cycle.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          set_busy,
  input  logic [AW-1:0] busy_addr,
  input  logic          lwe,
  input  logic [AW-1:0] lwa,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic          rd1_busy,
  output logic          rd2_busy
);

  localparam bit BYP = (BYPASS != 0);

  logic [NREG-1:0] pend;
  logic            set_v;
  logic            clr_v;
  logic            fwd1;
  logic            fwd2;

  assign set_v = run && set_busy && (busy_addr != '0);
  assign clr_v = run && lwe;

  // NOTE: sequential state uses non-blocking assignments only, so every bit reads pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (set_v && busy_addr == AW'(i)) pend[i] <= 1'b1;
        else if (clr_v && lwa == AW'(i)) pend[i] <= 1'b0;
      end
    end
  end

  // A returning load forwards its data this cycle, so it is not busy unless it is re-issued in the same cycle.
  assign fwd1 = BYP && clr_v && (lwa == ra1) && !(set_v && busy_addr == ra1);
  assign fwd2 = BYP && clr_v && (lwa == ra2) && !(set_v && busy_addr == ra2);

  assign rd1_busy = run && pend[ra1] && !fwd1;
  assign rd2_busy = run && pend[ra2] && !fwd2;

endmodule

// File: rtl/regfile_mp_sb.sv
// Register file with 2 read ports and 2 write ports (ALU port A, load-return port L).
// It has optional bypass, a load scoreboard, and a post-reset init sweep that fills the array.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN      = 32,
  parameter  int NREG      = 32,
  parameter  int INIT_MODE = 1,
  parameter  int BYPASS    = 1,
  localparam int AW        = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            rd1_busy,
  output logic            rd2_busy,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wdata,
  input  logic            we,
  input  logic [AW-1:0]   lwa,
  input  logic [XLEN-1:0] lwdata,
  input  logic            lwe,
  input  logic            set_busy,
  input  logic [AW-1:0]   busy_addr,
  output logic            init_done
);

  localparam bit BYP = (BYPASS != 0);

  rf_state_e       state, state_next;
  logic [AW-1:0]   cnt, cnt_next;
  logic            init_done_next;
  logic            run;
  logic            a_wr;
  logic            l_wr;
  logic [XLEN-1:0] init_val;
  logic [XLEN-1:0] mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RF_INIT;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      init_done <= init_done_next;
    end
  end

  // NOTE: defaults come first so that every path assigns every output and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      RF_INIT: begin
        cnt_next = cnt + AW'(1);
        if (cnt == AW'(NREG - 1)) state_next = RF_RUN;
      end
      default: ;
    endcase
    init_done_next = (state_next == RF_RUN);
  end

  assign run      = (state == RF_RUN);
  assign a_wr     = run && we && (wa != '0);
  assign l_wr     = run && lwe && (lwa != '0);
  assign init_val = XLEN'(rf_init_val(32'(cnt), INIT_MODE));

  // NOTE: the array has no reset. The init sweep loads known values into it after each reset.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[cnt] <= init_val;
    end else begin
      // Port A is written last, so it wins when both ports target the same address.
      if (l_wr) mem[lwa] <= lwdata;
      if (a_wr) mem[wa]  <= wdata;
    end
  end

  assign rd1 = (!run || ra1 == '0)          ? '0     :
               (BYP && a_wr && wa  == ra1)  ? wdata  :
               (BYP && l_wr && lwa == ra1)  ? lwdata : mem[ra1];

  assign rd2 = (!run || ra2 == '0)          ? '0     :
               (BYP && a_wr && wa  == ra2)  ? wdata  :
               (BYP && l_wr && lwa == ra2)  ? lwdata : mem[ra2];

  regfile_scoreboard #(
    .NREG  (NREG),
    .AW    (AW),
    .BYPASS(BYPASS)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .set_busy (set_busy),
    .busy_addr(busy_addr),
    .lwe      (lwe),
    .lwa      (lwa),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1_busy (rd1_busy),
    .rd2_busy (rd2_busy)
  );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb. It drives a bypassing copy and a non-bypassing copy from the same inputs.
// Both copies are compared against an array-level reference model of the register file.
module tb_regfile_mp_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk;
  logic            rst_n;
  logic [AW-1:0]   ra1, ra2, wa, lwa, busy_addr;
  logic [XLEN-1:0] wdata, lwdata;
  logic            we, lwe, set_busy;

  logic [XLEN-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic            busy1_b, busy2_b, busy1_n, busy2_n;
  logic            done_b, done_n;

  logic [XLEN-1:0] obs_rd [4];
  logic            obs_busy [4];

  logic [XLEN-1:0] m_mem [NREG];
  bit              m_pend [NREG];
  bit              m_run;
  int              m_idx;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .INIT_MODE(1), .BYPASS(1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .rd1_busy(busy1_b), .rd2_busy(busy2_b), .wa(wa), .wdata(wdata), .we(we),
    .lwa(lwa), .lwdata(lwdata), .lwe(lwe), .set_busy(set_busy),
    .busy_addr(busy_addr), .init_done(done_b)
  );

  regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .INIT_MODE(1), .BYPASS(0)) dut_nob (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
    .rd1_busy(busy1_n), .rd2_busy(busy2_n), .wa(wa), .wdata(wdata), .we(we),
    .lwa(lwa), .lwdata(lwdata), .lwe(lwe), .set_busy(set_busy),
    .busy_addr(busy_addr), .init_done(done_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  always_comb begin
    obs_rd[0]   = rd1_b;   obs_rd[1]   = rd2_b;   obs_rd[2]   = rd1_n;   obs_rd[3]   = rd2_n;
    obs_busy[0] = busy1_b; obs_busy[1] = busy2_b; obs_busy[2] = busy1_n; obs_busy[3] = busy2_n;
  end

  // Ports 0 and 1 are the bypassing copy. Ports 2 and 3 are the non-bypassing copy.
  function automatic logic [XLEN-1:0] exp_rd(input int k);
    logic [AW-1:0] a;
    bit byp;
    a   = (k % 2 == 0) ? ra1 : ra2;
    byp = (k < 2);
    if (!m_run || a == 0) return '0;
    if (byp && we && wa == a) return wdata;
    if (byp && lwe && lwa == a) return lwdata;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input int k);
    logic [AW-1:0] a;
    bit byp;
    a   = (k % 2 == 0) ? ra1 : ra2;
    byp = (k < 2);
    if (!m_run || a == 0) return 1'b0;
    if (byp && lwe && lwa == a && !(set_busy && busy_addr == a)) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_idx = 0;
    for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
  endtask

  task automatic model_clock();
    if (!m_run) begin
      m_mem[m_idx] = 32'(m_idx);
      m_idx++;
      if (m_idx == NREG) m_run = 1'b1;
    end else begin
      if (lwe && lwa != 0) m_mem[lwa] = lwdata;
      if (we && wa != 0) m_mem[wa] = wdata;
      if (lwe) m_pend[lwa] = 1'b0;
      if (set_busy && busy_addr != 0) m_pend[busy_addr] = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; lwe = 0; set_busy = 0;
    wa = '0; lwa = '0; busy_addr = '0; wdata = '0; lwdata = '0;
  endtask

  task automatic test_reset();
    int cycles;
    idle();
    ra1 = 5'd5; ra2 = 5'd31;
    rst_n = 1'b0;
    model_reset();
    #2;
    n_checks++; if (done_b !== 1'b0 || done_n !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b/%b want 0", done_b, done_n); end
    n_checks++; if (rd1_b !== '0 || rd2_n !== '0) begin n_fail++; $display("FAIL reset_rd: got %h/%h want 0", rd1_b, rd2_n); end
    n_checks++; if (busy1_b !== 1'b0 || busy2_n !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b/%b want 0", busy1_b, busy2_n); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    cycles = 0;
    while (!done_b && cycles < 40) begin
      ra1 = AW'(cycles + 1);
      #1;
      n_checks++; if (rd1_b !== '0 || busy1_b !== 1'b0) begin n_fail++; $display("FAIL init_rd_zero cycle %0d: got %h/%b want 0/0", cycles, rd1_b, busy1_b); end
      step();
      cycles++;
    end
    n_checks++; if (cycles !== NREG) begin n_fail++; $display("FAIL sweep_length: got %0d want %0d", cycles, NREG); end
    n_checks++; if (done_n !== 1'b1 || done_b !== m_run) begin n_fail++; $display("FAIL init_done_high: got %b/%b want 1", done_b, done_n); end
    ra1 = 5'd5; ra2 = 5'd31;
    #1;
    n_checks++; if (rd1_b !== 32'h5 || rd1_n !== 32'h5) begin n_fail++; $display("FAIL init_val_5: got %h/%h want 5", rd1_b, rd1_n); end
    n_checks++; if (rd2_b !== 32'h1F || rd2_n !== 32'h1F) begin n_fail++; $display("FAIL init_val_31: got %h/%h want 1f", rd2_b, rd2_n); end
    ra1 = 5'd0;
    #1;
    n_checks++; if (rd1_b !== '0 || rd1_n !== '0) begin n_fail++; $display("FAIL init_val_0: got %h/%h want 0", rd1_b, rd1_n); end
  endtask

  task automatic test_bypass();
    idle();
    we = 1; wa = 5'd3; wdata = 32'hDEADBEEF; ra1 = 5'd3; ra2 = 5'd3;
    #1;
    n_checks++; if (rd1_b !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_same_cycle: got %h want deadbeef", rd1_b); end
    n_checks++; if (rd2_n !== 32'h3) begin n_fail++; $display("FAIL nobypass_same_cycle: got %h want 3", rd2_n); end
    step();
    idle();
    #1;
    n_checks++; if (rd1_n !== 32'hDEADBEEF || rd1_b !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_next_cycle: got %h/%h want deadbeef", rd1_b, rd1_n); end
  endtask

  task automatic test_port_conflict();
    idle();
    set_busy = 1; busy_addr = 5'd7; ra1 = 5'd7; ra2 = 5'd1;
    step();
    idle();
    #1;
    n_checks++; if (busy1_b !== 1'b1 || busy1_n !== 1'b1) begin n_fail++; $display("FAIL conflict_pend_set: got %b/%b want 1", busy1_b, busy1_n); end
    we = 1; wa = 5'd7; wdata = 32'h11; lwe = 1; lwa = 5'd7; lwdata = 32'h22;
    #1;
    n_checks++; if (rd1_b !== 32'h11) begin n_fail++; $display("FAIL conflict_bypass_prio: got %h want 11", rd1_b); end
    n_checks++; if (busy1_b !== 1'b0 || busy1_n !== 1'b1) begin n_fail++; $display("FAIL conflict_busy_same_cycle: got %b/%b want 0/1", busy1_b, busy1_n); end
    step();
    idle();
    #1;
    n_checks++; if (rd1_b !== 32'h11 || rd1_n !== 32'h11) begin n_fail++; $display("FAIL conflict_port_a_wins: got %h/%h want 11", rd1_b, rd1_n); end
    n_checks++; if (busy1_b !== 1'b0 || busy1_n !== 1'b0) begin n_fail++; $display("FAIL conflict_pend_cleared: got %b/%b want 0", busy1_b, busy1_n); end
  endtask

  task automatic test_scoreboard();
    idle();
    set_busy = 1; busy_addr = 5'd9; ra1 = 5'd9; ra2 = 5'd8;
    step();
    idle();
    #1;
    n_checks++; if (busy1_b !== 1'b1 || busy1_n !== 1'b1 || busy2_b !== 1'b0) begin n_fail++; $display("FAIL sb_set: got %b/%b/%b want 1/1/0", busy1_b, busy1_n, busy2_b); end
    step();
    n_checks++; if (busy1_b !== 1'b1) begin n_fail++; $display("FAIL sb_hold: got %b want 1", busy1_b); end
    lwe = 1; lwa = 5'd9; lwdata = 32'h99;
    #1;
    n_checks++; if (rd1_b !== 32'h99 || busy1_b !== 1'b0) begin n_fail++; $display("FAIL sb_return_fwd: got %h/%b want 99/0", rd1_b, busy1_b); end
    n_checks++; if (rd1_n !== 32'h9 || busy1_n !== 1'b1) begin n_fail++; $display("FAIL sb_return_nofwd: got %h/%b want 9/1", rd1_n, busy1_n); end
    step();
    idle();
    #1;
    n_checks++; if (busy1_b !== 1'b0 || busy1_n !== 1'b0 || rd1_n !== 32'h99) begin n_fail++; $display("FAIL sb_after_return: got %b/%b/%h want 0/0/99", busy1_b, busy1_n, rd1_n); end
    set_busy = 1; busy_addr = 5'd9;
    step();
    lwe = 1; lwa = 5'd9; lwdata = 32'h9A; set_busy = 1; busy_addr = 5'd9;
    #1;
    n_checks++; if (busy1_b !== 1'b1 || busy1_n !== 1'b1) begin n_fail++; $display("FAIL sb_reset_same_cycle: got %b/%b want 1", busy1_b, busy1_n); end
    step();
    idle();
    #1;
    n_checks++; if (busy1_b !== 1'b1 || busy1_n !== 1'b1 || rd1_b !== 32'h9A) begin n_fail++; $display("FAIL sb_set_wins: got %b/%b/%h want 1/1/9a", busy1_b, busy1_n, rd1_b); end
    lwe = 1; lwa = 5'd9; lwdata = 32'h9B;
    step();
    idle();
  endtask

  task automatic test_x0();
    idle();
    we = 1; wa = 5'd0; wdata = 32'hFFFFFFFF; lwe = 1; lwa = 5'd0; lwdata = 32'hFFFFFFFF; ra1 = 5'd0; ra2 = 5'd0;
    #1;
    n_checks++; if (rd1_b !== '0 || rd2_n !== '0) begin n_fail++; $display("FAIL x0_write_bypass: got %h/%h want 0", rd1_b, rd2_n); end
    step();
    idle();
    set_busy = 1; busy_addr = 5'd0;
    step();
    idle();
    #1;
    n_checks++; if (rd1_b !== '0 || rd1_n !== '0 || busy1_b !== 1'b0 || busy1_n !== 1'b0) begin n_fail++; $display("FAIL x0_after: got %h/%h/%b/%b want 0", rd1_b, rd1_n, busy1_b, busy1_n); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom); lwe = 1'($urandom); set_busy = 1'($urandom);
      wa        = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      lwa       = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      busy_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      ra1       = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      ra2       = AW'($urandom);
      wdata = $urandom; lwdata = $urandom;
      #1;
      for (int k = 0; k < 4; k++) begin
        n_checks++; if (obs_rd[k] !== exp_rd(k)) begin n_fail++; $display("FAIL rand_rd[%0d] iter %0d: got %h want %h", k, i, obs_rd[k], exp_rd(k)); end
        n_checks++; if (obs_busy[k] !== exp_busy(k)) begin n_fail++; $display("FAIL rand_busy[%0d] iter %0d: got %b want %b", k, i, obs_busy[k], exp_busy(k)); end
      end
      step();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    int cycles;
    idle();
    set_busy = 1; busy_addr = 5'd4; ra1 = 5'd4; ra2 = 5'd4;
    step();
    idle();
    #1;
    n_checks++; if (busy1_b !== 1'b1 || busy2_n !== 1'b1) begin n_fail++; $display("FAIL rst_run_pend4: got %b/%b want 1", busy1_b, busy2_n); end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (done_b !== 1'b0 || done_n !== 1'b0 || busy1_b !== 1'b0) begin n_fail++; $display("FAIL rst_run_async: got %b/%b/%b want 0", done_b, done_n, busy1_b); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    repeat (10) step();
    n_checks++; if (done_b !== 1'b0) begin n_fail++; $display("FAIL rst_midsweep_done: got %b want 0", done_b); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cycles = 0;
    while (!done_n && cycles < 40) begin
      if (cycles == 20) begin we = 1; wa = 5'd2; wdata = 32'h55; end
      else we = 0;
      step();
      cycles++;
    end
    idle();
    n_checks++; if (cycles !== NREG) begin n_fail++; $display("FAIL rst_resweep_length: got %0d want %0d", cycles, NREG); end
    ra1 = 5'd2; ra2 = 5'd4;
    #1;
    n_checks++; if (rd1_b !== 32'h2 || rd1_n !== 32'h2) begin n_fail++; $display("FAIL rst_init_write_lost: got %h/%h want 2", rd1_b, rd1_n); end
    n_checks++; if (busy2_b !== 1'b0 || busy2_n !== 1'b0) begin n_fail++; $display("FAIL rst_pend_cleared: got %b/%b want 0", busy2_b, busy2_n); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (obs_rd[k] !== exp_rd(k)) begin n_fail++; $display("FAIL rst_model_rd[%0d]: got %h want %h", k, obs_rd[k], exp_rd(k)); end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_port_conflict();
    test_scoreboard();
    test_x0();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
